// File: rtl/icache_if.sv
// Fetch and memory handshake bundle shared between the instruction cache
// and its environment. The slave side is the cache.
interface icache_if;
   logic        in_fetcher_ena;
   logic [31:0] in_fetcher_addr;
   logic        out_fetcher_ok;
   logic [31:0] out_fetcher_data;
   logic        out_mem_ena;
   logic [31:0] out_mem_addr;
   logic        in_mem_ok;
   logic [31:0] in_mem_data;

   modport slave (
      input  in_fetcher_ena, in_fetcher_addr, in_mem_ok, in_mem_data,
      output out_fetcher_ok, out_fetcher_data, out_mem_ena, out_mem_addr
   );

   modport master (
      output in_fetcher_ena, in_fetcher_addr, in_mem_ok, in_mem_data,
      input  out_fetcher_ok, out_fetcher_data, out_mem_ena, out_mem_addr
   );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
//
//   state | meaning
//   IDLE  | waiting for a fetch request; hit lookup happens here
//   MISS  | word read outstanding at the memory unit
//   RESP  | out_fetcher_ok pulse cycle, back to IDLE afterwards
module icache #(
   parameter int INDEX_WIDTH = 6,
   parameter int TAG_WIDTH   = 10
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      ena,
   input  logic      in_flush,
   icache_if.slave   bus
);
   localparam int LINES   = 1 << INDEX_WIDTH;
   localparam int TAG_LSB = INDEX_WIDTH + 2;
   localparam int TAG_MSB = INDEX_WIDTH + TAG_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

   state_t                 r_state;
   logic [LINES-1:0]       r_valid;
   logic [TAG_WIDTH-1:0]   r_tag  [LINES];
   logic [31:0]            r_data [LINES];
   logic                   r_ok;
   logic [31:0]            r_fdata;
   logic                   r_mem_ena;
   logic [31:0]            r_mem_addr;

   logic [INDEX_WIDTH-1:0] w_req_index;
   logic [TAG_WIDTH-1:0]   w_req_tag;
   logic [INDEX_WIDTH-1:0] w_fill_index;
   logic [TAG_WIDTH-1:0]   w_fill_tag;
   logic                   w_hit;
   logic                   w_fill;
   logic                   w_unused;

   // The fill line comes from the latched miss address, not the live
   // request, so a misbehaving fetcher cannot corrupt another line.
   assign w_req_index  = bus.in_fetcher_addr[INDEX_WIDTH+1:2];
   assign w_req_tag    = bus.in_fetcher_addr[TAG_MSB:TAG_LSB];
   assign w_fill_index = r_mem_addr[INDEX_WIDTH+1:2];
   assign w_fill_tag   = r_mem_addr[TAG_MSB:TAG_LSB];
   assign w_hit        = r_valid[w_req_index] && (r_tag[w_req_index] == w_req_tag);
   assign w_fill       = rst && ena && !in_flush && (r_state == MISS) && bus.in_mem_ok;

   // Address bits above the tag alias onto the same line; byte offset is ignored.
   assign w_unused = ^{bus.in_fetcher_addr[31:TAG_MSB+1], bus.in_fetcher_addr[1:0]};

   assign bus.out_fetcher_ok   = r_ok;
   assign bus.out_fetcher_data = r_fdata;
   assign bus.out_mem_ena      = r_mem_ena;
   assign bus.out_mem_addr     = r_mem_addr;

   // Tag and data storage; written only on a completed, unflushed miss.
   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_tag[w_fill_index]  <= w_fill_tag;
         r_data[w_fill_index] <= bus.in_mem_data;
      end
   end

   // Control FSM with registered outputs and line valid bits.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_valid    <= '0;
         r_ok       <= 1'b0;
         r_fdata    <= '0;
         r_mem_ena  <= 1'b0;
         r_mem_addr <= '0;
      end else if (ena) begin
         if (in_flush) begin
            r_state   <= IDLE;
            r_ok      <= 1'b0;
            r_mem_ena <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_ok <= 1'b0;
                  if (bus.in_fetcher_ena) begin
                     if (w_hit) begin
                        r_fdata <= r_data[w_req_index];
                        r_ok    <= 1'b1;
                        r_state <= RESP;
                     end else begin
                        r_mem_addr <= {bus.in_fetcher_addr[31:2], 2'b00};
                        r_mem_ena  <= 1'b1;
                        r_state    <= MISS;
                     end
                  end
               end
               MISS: begin
                  if (bus.in_mem_ok) begin
                     r_valid[w_fill_index] <= 1'b1;
                     r_fdata               <= bus.in_mem_data;
                     r_mem_ena             <= 1'b0;
                     r_ok                  <= 1'b1;
                     r_state               <= RESP;
                  end
               end
               RESP: begin
                  r_ok    <= 1'b0;
                  r_state <= IDLE;
               end
               default: begin
                  r_ok      <= 1'b0;
                  r_mem_ena <= 1'b0;
                  r_state   <= IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_icache;
   logic clk;
   logic rst;
   logic ena;
   logic in_flush;

   icache_if bus ();

   icache dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .in_flush (in_flush),
      .bus      (bus)
   );

   int n_pass;
   int n_total;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: a 64-entry table plus the visible outputs.
   // "Waiting on memory" is simply m_mem_ena, "responding" is m_ok.
   bit          m_valid [64];
   logic [9:0]  m_tag   [64];
   logic [31:0] m_data  [64];
   logic        m_ok;
   logic [31:0] m_fdata;
   logic        m_mem_ena;
   logic [31:0] m_mem_addr;

   always @(posedge clk) begin
      int idx;
      int tg;
      if (!rst) begin
         for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
         m_ok = 0; m_fdata = 0; m_mem_ena = 0; m_mem_addr = 0;
      end else if (ena) begin
         if (in_flush) begin
            m_ok = 0;
            m_mem_ena = 0;
         end else if (m_ok) begin
            m_ok = 0;
         end else if (m_mem_ena) begin
            if (bus.in_mem_ok) begin
               idx = int'((m_mem_addr >> 2) % 64);
               tg  = int'((m_mem_addr >> 8) % 1024);
               m_valid[idx] = 1'b1;
               m_tag[idx]   = tg[9:0];
               m_data[idx]  = bus.in_mem_data;
               m_fdata      = bus.in_mem_data;
               m_ok         = 1;
               m_mem_ena    = 0;
            end
         end else if (bus.in_fetcher_ena) begin
            idx = int'((bus.in_fetcher_addr >> 2) % 64);
            tg  = int'((bus.in_fetcher_addr >> 8) % 1024);
            if (m_valid[idx] && m_tag[idx] == tg[9:0]) begin
               m_fdata = m_data[idx];
               m_ok    = 1;
            end else begin
               m_mem_addr = bus.in_fetcher_addr & 32'hFFFF_FFFC;
               m_mem_ena  = 1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      check("model_ok",       {31'd0, bus.out_fetcher_ok}, {31'd0, m_ok});
      check("model_data",     bus.out_fetcher_data,        m_fdata);
      check("model_mem_ena",  {31'd0, bus.out_mem_ena},    {31'd0, m_mem_ena});
      check("model_mem_addr", bus.out_mem_addr,            m_mem_addr);
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic ok, input logic [31:0] data,
                             input logic mem_ena, input logic [31:0] mem_addr);
      check({name, "_ok"},       {31'd0, bus.out_fetcher_ok}, {31'd0, ok});
      check({name, "_data"},     bus.out_fetcher_data,        data);
      check({name, "_mem_ena"},  {31'd0, bus.out_mem_ena},    {31'd0, mem_ena});
      check({name, "_mem_addr"}, bus.out_mem_addr,            mem_addr);
   endtask

   task automatic fetch(input logic [31:0] a);
      bus.in_fetcher_ena  = 1'b1;
      bus.in_fetcher_addr = a;
   endtask

   task automatic mem_reply(input logic [31:0] d);
      bus.in_mem_ok   = 1'b1;
      bus.in_mem_data = d;
   endtask

   task automatic idle_inputs();
      bus.in_fetcher_ena = 1'b0;
      bus.in_mem_ok      = 1'b0;
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst = 1'b0; ena = 1'b1; in_flush = 1'b0;
      bus.in_fetcher_ena = 1'b0; bus.in_fetcher_addr = '0;
      bus.in_mem_ok = 1'b0; bus.in_mem_data = '0;

      step();
      expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
      step();
      rst = 1'b1;
      step();

      // cold miss then fill
      fetch(32'h0000_0000);
      step();
      expect_out("cold_miss", 1'b0, 32'h0, 1'b1, 32'h0);
      mem_reply(32'h0000_0413);
      step();
      expect_out("cold_fill", 1'b1, 32'h0000_0413, 1'b0, 32'h0);
      idle_inputs();
      step();
      check("cold_ok_drop", {31'd0, bus.out_fetcher_ok}, 32'd0);

      // hit, latency one
      fetch(32'h0000_0000);
      step();
      expect_out("hit", 1'b1, 32'h0000_0413, 1'b0, 32'h0);
      idle_inputs();
      step();

      // conflict on index 0
      fetch(32'h0000_0100);
      step();
      expect_out("conf_miss", 1'b0, 32'h0000_0413, 1'b1, 32'h0000_0100);
      mem_reply(32'h0010_0093);
      step();
      expect_out("conf_fill", 1'b1, 32'h0010_0093, 1'b0, 32'h0000_0100);
      idle_inputs();
      step();
      fetch(32'h0000_0000);
      step();
      expect_out("conf_remiss", 1'b0, 32'h0010_0093, 1'b1, 32'h0);
      mem_reply(32'h0000_0413);
      step();
      idle_inputs();
      step();

      // flush during miss, late memory reply ignored
      fetch(32'h0000_0004);
      step();
      check("flush_pre", bus.out_mem_addr, 32'h0000_0004);
      in_flush = 1'b1;
      bus.in_fetcher_ena = 1'b0;
      step();
      in_flush = 1'b0;
      check("flush_mem_ena", {31'd0, bus.out_mem_ena}, 32'd0);
      mem_reply(32'hDEAD_BEEF);
      step();
      check("flush_no_ok", {31'd0, bus.out_fetcher_ok}, 32'd0);
      idle_inputs();
      fetch(32'h0000_0004);
      step();
      check("flush_remiss", {31'd0, bus.out_mem_ena}, 32'd1);
      mem_reply(32'h0000_1234);
      step();
      check("flush_fill", bus.out_fetcher_data, 32'h0000_1234);
      idle_inputs();
      step();

      // freeze during miss with memory reply present
      fetch(32'h0000_0008);
      step();
      ena = 1'b0;
      mem_reply(32'h5555_5555);
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out("freeze", 1'b0, 32'h0000_1234, 1'b1, 32'h0000_0008);
      end
      ena = 1'b1;
      bus.in_mem_ok = 1'b0;
      step();
      expect_out("unfreeze", 1'b0, 32'h0000_1234, 1'b1, 32'h0000_0008);
      mem_reply(32'h0000_0777);
      step();
      check("freeze_fill", bus.out_fetcher_data, 32'h0000_0777);
      idle_inputs();
      step();

      // reset during miss
      fetch(32'h0000_000C);
      step();
      rst = 1'b0;
      mem_reply(32'h0BAD_0BAD);
      step();
      expect_out("rst_miss", 1'b0, 32'h0, 1'b0, 32'h0);
      rst = 1'b1;
      bus.in_mem_ok = 1'b0;
      step();
      expect_out("rst_remiss", 1'b0, 32'h0, 1'b1, 32'h0000_000C);
      mem_reply(32'h0000_00CC);
      step();
      idle_inputs();
      step();

      // upper address bits alias onto line 0 (refilled cold miss above was lost to reset)
      fetch(32'h0000_0000);
      step();
      mem_reply(32'h0000_0413);
      step();
      idle_inputs();
      step();
      fetch(32'hABC0_0000);
      step();
      expect_out("alias_hit", 1'b1, 32'h0000_0413, 1'b0, 32'h0);
      idle_inputs();
      step();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 199) != 0);
         ena      = ($urandom_range(0, 9) != 0);
         in_flush = ($urandom_range(0, 24) == 0);
         if (!rst || in_flush) begin
            bus.in_fetcher_ena = 1'b0;
         end else if (bus.out_fetcher_ok) begin
            bus.in_fetcher_ena = 1'b0;
         end else if (!bus.in_fetcher_ena && $urandom_range(0, 2) == 0) begin
            bus.in_fetcher_ena  = 1'b1;
            bus.in_fetcher_addr = ($urandom & 32'hFFFC_0000)
                                | (32'($urandom_range(0, 3)) << 8)
                                | (32'($urandom_range(0, 7)) << 2)
                                | ($urandom & 32'h3);
         end
         bus.in_mem_ok   = bus.out_mem_ena ? ($urandom_range(0, 3) == 0)
                                           : ($urandom_range(0, 19) == 0);
         bus.in_mem_data = $urandom;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_WIDTH, default 6, log2 of line count (64 lines, one 32-bit word per line).
REQ-002 Parameter TAG_WIDTH, default 10, stored tag bits, address bits [17:8] at default INDEX_WIDTH.
REQ-003 Clocking SHALL be one clock; reset SHALL be synchronous and active-low.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 ena  input  1  ready; low freezes all state and outputs.
REQ-007 in_flush  input  1  pipeline redirect; aborts the in-flight request.
REQ-008 in_fetcher_ena  input  1  fetch request valid; held until out_fetcher_ok.
REQ-009 in_fetcher_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-010 out_fetcher_ok  output  1  one-cycle pulse; out_fetcher_data valid.
REQ-011 out_fetcher_data  output  32  instruction word.
REQ-012 out_mem_ena  output  1  word read request to memory unit.
REQ-013 out_mem_addr  output  32  word-aligned read address.
REQ-014 in_mem_ok  input  1  memory word read complete.
REQ-015 in_mem_data  input  32  memory read word, valid with in_mem_ok.

Function
REQ-016 Storage: per line valid bit, TAG_WIDTH tag, 32-bit data; direct-mapped; index = addr[INDEX_WIDTH+1:2], tag = addr[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2].
REQ-017 FSM states SHALL be IDLE, MISS, RESP.
REQ-018 IDLE, ena=1, in_flush=0, in_fetcher_ena=1, hit: register line data into out_fetcher_data, go RESP; out_fetcher_ok=1 in the following cycle (latency 1).
REQ-019 IDLE, request, miss: register out_mem_addr={addr[31:2],2'b00}, out_mem_ena=1, go MISS.
REQ-020 MISS: out_mem_ena and out_mem_addr SHALL stay constant until in_mem_ok.
REQ-021 MISS, in_mem_ok=1, in_flush=0: write valid=1, tag, data to line; out_fetcher_data=in_mem_data; out_mem_ena=0; go RESP.
REQ-022 RESP: out_fetcher_ok=1 for exactly this cycle; in_fetcher_ena ignored; next state IDLE; max throughput one hit per 2 cycles.
REQ-023 out_fetcher_ok SHALL be 0 in IDLE and MISS.
REQ-024 in_flush=1 (ena=1) from any state: next state IDLE, out_mem_ena=0, out_fetcher_ok=0 next cycle, no line written; valid bits retained.
REQ-025 in_flush and in_mem_ok in the same cycle: flush wins; line not written, no ok pulse.
REQ-026 Flush in RESP: suppress the ok pulse for the following cycle; current-cycle ok unaffected.
REQ-027 ena=0: no state, storage, or output change; in_mem_ok during ena=0 is not captured.
REQ-028 Request with in_fetcher_ena=0 in IDLE: stay IDLE, outputs unchanged.
REQ-029 Address wrap: only index/tag bits used; addresses differing only above bit INDEX_WIDTH+TAG_WIDTH+1 alias.

Reset
REQ-030 rst=0 at a rising edge (regardless of ena): state IDLE, all valid bits 0, out_fetcher_ok=0, out_fetcher_data=0, out_mem_ena=0, out_mem_addr=0.
REQ-031 Reset mid-miss SHALL abandon the request; no line written.

Verification
REQ-032 Cold miss: request 0x00000000 after reset -> out_mem_ena=1, out_mem_addr=0x0; in_mem_ok with 0x00000413 -> next cycle out_fetcher_ok=1, data 0x00000413.
REQ-033 Hit: re-request 0x00000000 -> out_fetcher_ok=1 one cycle later, data 0x00000413, out_mem_ena stays 0.
REQ-034 Conflict: fill 0x00000000, then 0x00000100 (same index) -> miss, fill 0x00100093; then 0x00000000 -> miss again.
REQ-035 Flush mid-miss: in_flush during MISS, then in_mem_ok -> no ok pulse; later 0x00000004 request misses (line not filled).
REQ-036 Freeze: ena=0 for 3 cycles during MISS with in_mem_ok pulsed -> no state change; after ena=1 FSM remains MISS with out_mem_addr unchanged.
REQ-037 Reset mid-miss: rst=0 during MISS -> all outputs 0; subsequent request to same address misses.
